// File: rtl/clock_pkg.sv
// Shared types, constants and BCD helpers for the multi_mode_clock core.
package clock_pkg;

  typedef logic [7:0] bcd8_t;

  localparam bcd8_t BCD_59 = 8'h59;
  localparam bcd8_t BCD_23 = 8'h23;
  localparam bcd8_t BCD_12 = 8'h12;

  // Increment a two-digit BCD value; the caller handles the modulus wrap.
  function automatic bcd8_t bcd_inc(input bcd8_t v);
    bcd8_t r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Map a 24-hour BCD hour onto the 12-hour face (00 shows as 12).
  function automatic bcd8_t bcd_to_12h(input bcd8_t h);
    bcd8_t r;
    if (h == 8'h00)                    r = BCD_12;
    else if (h <= BCD_12)              r = h;
    else if (h <= 8'h19)               r = h - 8'h12;
    else if (h == 8'h20)               r = 8'h08;
    else if (h == 8'h21)               r = 8'h09;
    else if (h == 8'h22)               r = 8'h10;
    else if (h == 8'h23)               r = 8'h11;
    else                               r = h;
    return r;
  endfunction

  // Two-digit BCD to binary, used for minute arithmetic.
  function automatic logic [6:0] bcd_to_bin(input bcd8_t v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  // Binary 0..99 back to two-digit BCD.
  function automatic bcd8_t bin_to_bcd(input logic [6:0] b);
    return {4'(b / 7'd10), 4'(b % 7'd10)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps at MAX and reports a carry on the wrap.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd8_t MAX = BCD_59
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  inc,
  input  logic  clr,
  output bcd8_t q,
  output logic  carry
);

  // A clear suppresses both the count and the carry it would have produced.
  assign carry = inc && !clr && (q == MAX);

  // Clear wins over increment; increment wraps MAX back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       q <= '0;
    else if (clr)     q <= '0;
    else if (inc)     q <= (q == MAX) ? 8'h00 : bcd_inc(q);
  end

endmodule

// File: rtl/multi_mode_clock.sv
// Digital clock core: BCD time of day from a divided seconds tick, 12/24-hour
// display, edge-triggered manual adjust, hourly chime and latched alarm.
// Optional snooze support is compiled in when CLOCK_SNOOZE_EN is defined.
module multi_mode_clock
  import clock_pkg::*;
#(
  parameter int CLK_DIV    = 100000000,
  parameter int CHIME_LEN  = 8,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode_12h,
  input  logic       adjust_hour,
  input  logic       adjust_minute,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_min,
  input  logic       alarm_ack,
`ifdef CLOCK_SNOOZE_EN
  input  logic       snooze,
`endif
  output logic [7:0] hour,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       pm,
  output logic       tweet,
  output logic       alarm
);

  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CHIME_W = $clog2(CHIME_LEN + 1);

  logic [DIV_W-1:0]   div_cnt;
  logic               sec_tick;
  logic               hour_prev, minute_prev;
  logic               hour_adj, minute_adj;
  bcd8_t              sec_q, min_q, hour_q;
  logic               sec_carry, min_carry, day_carry_unused;
  logic               hour_roll, hour_inc;
  bcd8_t              min_after_tick, hour_after_inc;
  logic               alarm_match;
  logic [CHIME_W-1:0] chime_left;

  assign sec_tick  = en && (div_cnt == DIV_W'(CLK_DIV - 1));
  // Only a counting carry rolls the hour; a minute adjust never carries.
  assign hour_roll = min_carry && !minute_adj;
  assign hour_inc  = hour_roll || hour_adj;

  // Sample the adjust levels and register one pulse per rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_prev   <= 1'b0;
      minute_prev <= 1'b0;
      hour_adj    <= 1'b0;
      minute_adj  <= 1'b0;
    end else begin
      hour_prev   <= adjust_hour;
      minute_prev <= adjust_minute;
      hour_adj    <= adjust_hour && !hour_prev;
      minute_adj  <= adjust_minute && !minute_prev;
    end
  end

  // Seconds prescaler; a minute adjust restarts the current second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          div_cnt <= '0;
    else if (minute_adj) div_cnt <= '0;
    else if (en)         div_cnt <= sec_tick ? '0 : div_cnt + DIV_W'(1);
  end

  bcd_mod_counter #(.MAX(BCD_59)) u_sec (
    .clk(clk), .rst_n(rst_n), .inc(sec_tick), .clr(minute_adj),
    .q(sec_q), .carry(sec_carry)
  );

  bcd_mod_counter #(.MAX(BCD_59)) u_min (
    .clk(clk), .rst_n(rst_n), .inc(sec_carry || minute_adj), .clr(1'b0),
    .q(min_q), .carry(min_carry)
  );

  bcd_mod_counter #(.MAX(BCD_23)) u_hour (
    .clk(clk), .rst_n(rst_n), .inc(hour_inc), .clr(1'b0),
    .q(hour_q), .carry(day_carry_unused)
  );

  // hh:mm that the counters will hold after this edge, for the :00 compares.
  assign min_after_tick = (min_q == BCD_59) ? 8'h00 : bcd_inc(min_q);
  assign hour_after_inc = hour_inc ? ((hour_q == BCD_23) ? 8'h00 : bcd_inc(hour_q)) : hour_q;

  // Counters only ever hold valid BCD, so invalid alarm inputs cannot match.
  assign alarm_match = alarm_en && sec_carry &&
                       (hour_after_inc == alarm_hour) && (min_after_tick == alarm_min);

  // Hourly chime: restartable down-counter holding tweet for CHIME_LEN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chime_left <= '0;
      tweet      <= 1'b0;
    end else if (hour_roll) begin
      chime_left <= CHIME_W'(CHIME_LEN - 1);
      tweet      <= 1'b1;
    end else if (chime_left != '0) begin
      chime_left <= chime_left - CHIME_W'(1);
    end else begin
      tweet      <= 1'b0;
    end
  end

`ifdef CLOCK_SNOOZE_EN
  logic       snz_pending;
  bcd8_t      snz_hour, snz_min;
  logic [6:0] snz_sum;
  bcd8_t      snz_min_next, snz_hour_next;
  logic       snz_match;

  // Snooze target is now + SNOOZE_MIN minutes, wrapping into the next hour/day.
  always_comb begin
    snz_sum       = bcd_to_bin(min_q) + 7'(SNOOZE_MIN);
    snz_min_next  = bin_to_bcd(snz_sum);
    snz_hour_next = hour_q;
    if (snz_sum >= 7'd60) begin
      snz_min_next  = bin_to_bcd(snz_sum - 7'd60);
      snz_hour_next = (hour_q == BCD_23) ? 8'h00 : bcd_inc(hour_q);
    end
  end

  assign snz_match = snz_pending && sec_carry &&
                     (hour_after_inc == snz_hour) && (min_after_tick == snz_min);

  // Alarm latch with snooze: clear beats snooze, snooze beats a new match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm       <= 1'b0;
      snz_pending <= 1'b0;
      snz_hour    <= 8'h00;
      snz_min     <= 8'h00;
    end else if (alarm_ack || !alarm_en) begin
      alarm       <= 1'b0;
      snz_pending <= 1'b0;
    end else if (snooze && alarm) begin
      alarm       <= 1'b0;
      snz_pending <= 1'b1;
      snz_hour    <= snz_hour_next;
      snz_min     <= snz_min_next;
    end else if (alarm_match || snz_match) begin
      alarm <= 1'b1;
      if (snz_match) snz_pending <= 1'b0;
    end
  end
`else
  // SNOOZE_MIN only matters when snooze is built in.
  logic [6:0] snooze_cfg_unused;
  assign snooze_cfg_unused = 7'(SNOOZE_MIN);

  // Alarm latch: clear takes priority over a new match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      alarm <= 1'b0;
    else if (alarm_ack || !alarm_en) alarm <= 1'b0;
    else if (alarm_match)            alarm <= 1'b1;
  end
`endif

  assign hour = mode_12h ? bcd_to_12h(hour_q) : hour_q;
  assign min  = min_q;
  assign sec  = sec_q;
  assign pm   = (hour_q >= BCD_12);

endmodule

// File: tb/tb_multi_mode_clock.sv
// Scoreboard bench for multi_mode_clock with an integer time-of-day model.
`timescale 1ns/1ps
module tb_multi_mode_clock;

  localparam int CLK_DIV    = 4;
  localparam int CHIME_LEN  = 8;
  localparam int SNOOZE_MIN = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0, mode_12h = 1'b0;
  logic       adjust_hour = 1'b0, adjust_minute = 1'b0;
  logic       alarm_en = 1'b0, alarm_ack = 1'b0;
  logic [7:0] alarm_hour = 8'h00, alarm_min = 8'h00;
`ifdef CLOCK_SNOOZE_EN
  logic       snooze = 1'b0;
`endif
  logic [7:0] hour, min, sec;
  logic       pm, tweet, alarm;

  multi_mode_clock #(.CLK_DIV(CLK_DIV), .CHIME_LEN(CHIME_LEN), .SNOOZE_MIN(SNOOZE_MIN)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode_12h(mode_12h),
    .adjust_hour(adjust_hour), .adjust_minute(adjust_minute),
    .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .alarm_ack(alarm_ack),
`ifdef CLOCK_SNOOZE_EN
    .snooze(snooze),
`endif
    .hour(hour), .min(min), .sec(sec), .pm(pm), .tweet(tweet), .alarm(alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] hour, min, sec;
    logic       pm, tweet, alarm;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    fails = 0;
  string phase = "reset";

  // Reference model: time of day as plain integers plus a few event flags.
  int m_h, m_m, m_s, m_div, m_chime;
  bit m_prev_h, m_prev_m, m_pend_h, m_pend_m, m_alarm;
  bit m_snz_pend;
  int m_snz_target;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic bit from_bcd(input logic [7:0] b, input int maxv, output int v);
    v = int'(b[7:4]) * 10 + int'(b[3:0]);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (v <= maxv);
  endfunction

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_div = 0; m_chime = 0;
    m_prev_h = 0; m_prev_m = 0; m_pend_h = 0; m_pend_m = 0; m_alarm = 0;
    m_snz_pend = 0; m_snz_target = 0;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    bit tick, carry_h, match, av, snz_match;
    int h, m, s, ah, am;
    tick = en && (m_div == CLK_DIV - 1);
    h = m_h; m = m_m; s = m_s; carry_h = 0;
    if (m_pend_m) begin
      m = (m + 1) % 60; s = 0;
    end else if (tick) begin
      s++;
      if (s == 60) begin
        s = 0; m++;
        if (m == 60) begin m = 0; carry_h = 1; end
      end
    end
    if (m_pend_h || carry_h) h = (h + 1) % 24;
    if (m_pend_m) m_div = 0;
    else if (en) m_div = tick ? 0 : m_div + 1;
    av = from_bcd(alarm_hour, 23, ah);
    av = from_bcd(alarm_min, 59, am) && av;
    match = tick && !m_pend_m && (s == 0) && alarm_en && av && (ah == h) && (am == m);
    snz_match = tick && !m_pend_m && (s == 0) && m_snz_pend && (h * 60 + m == m_snz_target);
    if (alarm_ack || !alarm_en) begin
      m_alarm = 0; m_snz_pend = 0;
`ifdef CLOCK_SNOOZE_EN
    end else if (snooze && m_alarm) begin
      m_alarm = 0; m_snz_pend = 1;
      m_snz_target = (m_h * 60 + m_m + SNOOZE_MIN) % 1440;
`endif
    end else if (match || snz_match) begin
      m_alarm = 1;
      if (snz_match) m_snz_pend = 0;
    end
    if (carry_h) m_chime = CHIME_LEN;
    else if (m_chime > 0) m_chime--;
    m_pend_h = adjust_hour && !m_prev_h;   m_prev_h = adjust_hour;
    m_pend_m = adjust_minute && !m_prev_m; m_prev_m = adjust_minute;
    m_h = h; m_m = m; m_s = s;
  endtask

  function automatic exp_t expected_now();
    exp_t e;
    int dh;
    dh = m_h;
    if (mode_12h) begin
      if (m_h == 0) dh = 12;
      else if (m_h > 12) dh = m_h - 12;
    end
    e.tag = phase;
    e.hour = to_bcd(dh); e.min = to_bcd(m_m); e.sec = to_bcd(m_s);
    e.pm = (m_h >= 12); e.tweet = (m_chime > 0); e.alarm = m_alarm;
    return e;
  endfunction

  task automatic checkOutput(input exp_t e);
    checks++;
    if (hour !== e.hour || min !== e.min || sec !== e.sec ||
        pm !== e.pm || tweet !== e.tweet || alarm !== e.alarm) begin
      fails++;
      $display("[TB] FAIL %s @%0t: got %h:%h:%h pm=%b tweet=%b alarm=%b, expected %h:%h:%h pm=%b tweet=%b alarm=%b",
               e.tag, $time, hour, min, sec, pm, tweet, alarm,
               e.hour, e.min, e.sec, e.pm, e.tweet, e.alarm);
    end
  endtask

  // Run n clock cycles with the inputs as currently driven.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      exp_q.push_back(expected_now());
      #6;
    end
  endtask

  // Asynchronous reset check: outputs must clear before any clock edge.
  task automatic applyReset();
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput(expected_now());
    @(posedge clk);
    #6;
    rst_n = 1'b1;
  endtask

  task automatic set_time(input int h, input int m);
    int n;
    en = 1'b0; adjust_hour = 1'b0; adjust_minute = 1'b0;
    applyStimulus(2);
    n = 0;
    while (m_h != h && n < 30) begin
      adjust_hour = 1'b1; applyStimulus(1); adjust_hour = 1'b0; applyStimulus(1); n++;
    end
    n = 0;
    while (m_m != m && n < 70) begin
      adjust_minute = 1'b1; applyStimulus(1); adjust_minute = 1'b0; applyStimulus(1); n++;
    end
  endtask

  task automatic run_until(input int h, input int m, input int s, input int max_cycles);
    int n;
    n = 0;
    while (!(m_h == h && m_m == m && m_s == s) && n < max_cycles) begin
      applyStimulus(1); n++;
    end
    if (!(m_h == h && m_m == m && m_s == s)) begin
      checks++; fails++;
      $display("[TB] FAIL %s: timeout waiting for %0d:%0d:%0d, model at %0d:%0d:%0d",
               phase, h, m, s, m_h, m_m, m_s);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, sampled 1 ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int n;
    model_reset();
    #2;
    phase = "reset_24h"; applyReset();
    mode_12h = 1'b1;
    phase = "reset_12h"; applyReset();
    mode_12h = 1'b0;

    phase = "count_240"; en = 1'b1; applyStimulus(240);

    phase = "chime_preload"; set_time(0, 59);
    phase = "chime_rollover"; en = 1'b1; applyStimulus(240 + 14);

    phase = "hour23_12h"; set_time(23, 0); mode_12h = 1'b1; applyStimulus(2);
    set_time(23, 59);
    phase = "midnight_12h"; en = 1'b1; mode_12h = 1'b1; applyStimulus(244);
    phase = "midnight_24h"; mode_12h = 1'b0; applyStimulus(2);

    phase = "adjust_hold"; en = 1'b0; adjust_minute = 1'b1; applyStimulus(20);
    adjust_minute = 1'b0; applyStimulus(2);
    phase = "adjust_min_wrap"; set_time(m_h, 59);
    adjust_minute = 1'b1; applyStimulus(1); adjust_minute = 1'b0; applyStimulus(2);
    phase = "adjust_vs_tick"; en = 1'b1; applyStimulus(21);
    n = 0;
    while (m_div != 2 && n < 8) begin applyStimulus(1); n++; end
    adjust_minute = 1'b1; applyStimulus(1); adjust_minute = 1'b0; applyStimulus(3);
    phase = "both_adjusts"; en = 1'b0;
    adjust_minute = 1'b1; adjust_hour = 1'b1; applyStimulus(1);
    adjust_minute = 1'b0; adjust_hour = 1'b0; applyStimulus(2);

    phase = "alarm_set"; alarm_hour = 8'h07; alarm_min = 8'h30; alarm_en = 1'b1;
    set_time(7, 29); en = 1'b1;
    run_until(7, 29, 59, 400); run_until(7, 30, 0, 10); applyStimulus(3);
    phase = "alarm_ack"; alarm_ack = 1'b1; applyStimulus(1); alarm_ack = 1'b0; applyStimulus(2);
    phase = "alarm_again"; set_time(7, 29); en = 1'b1;
    run_until(7, 29, 59, 400); run_until(7, 30, 0, 10); applyStimulus(3);
    phase = "alarm_async_reset"; applyReset();

`ifdef CLOCK_SNOOZE_EN
    phase = "snooze"; alarm_hour = 8'h23; alarm_min = 8'h58; alarm_en = 1'b1;
    set_time(23, 57); en = 1'b1;
    run_until(23, 58, 0, 400); applyStimulus(2);
    snooze = 1'b1; applyStimulus(1); snooze = 1'b0;
    run_until(0, 3, 0, 2000); applyStimulus(4);
    alarm_ack = 1'b1; applyStimulus(1); alarm_ack = 1'b0;
`endif

    phase = "random";
    alarm_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 1000 == 500) set_time(int'($urandom_range(0, 23)), 59);
      if (i % 400 == 0) begin
        alarm_hour = to_bcd(m_h);
        alarm_min = ($urandom_range(0, 3) == 0) ? 8'h3A : to_bcd((m_m + 1) % 60);
      end
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 199) == 0) adjust_hour = ~adjust_hour;
      if ($urandom_range(0, 199) == 0) adjust_minute = ~adjust_minute;
      if ($urandom_range(0, 39) == 0) mode_12h = ~mode_12h;
      alarm_ack = ($urandom_range(0, 149) == 0);
      alarm_en = ($urandom_range(0, 299) != 0);
`ifdef CLOCK_SNOOZE_EN
      snooze = ($urandom_range(0, 99) == 0);
`endif
      applyStimulus(1);
    end

    applyStimulus(2);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
